muldiv_unit: RTL and testbench

- Parametrised HI/LO multiply-divide unit for the pipelined MIPS core, sitting beside the EX-stage ALU.
- Accepts signed/unsigned mult, div, multiply-accumulate and mthi/mtlo ops with configurable latency.
- Presents busy to the hazard unit so mfhi/mflo/md ops stall until the result is committed.
- Supports cancelling an issuing op when the issuing instruction is flushed by an exception.

---
 rtl/md_pkg.sv | 37 +++
 rtl/muldiv_core.sv | 65 ++++++
 rtl/muldiv_unit.sv | 122 ++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the HI/LO multiply-divide unit.
package md_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Ops that run for MULT_LAT cycles (plain and accumulating multiplies)
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == MD_MULT)  || (op == MD_MULTU) ||
           (op == MD_MADD)  || (op == MD_MADDU) ||
           (op == MD_MSUB)  || (op == MD_MSUBU);
  endfunction

  // Ops that run for DIV_LAT cycles
  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational HI/LO result datapath: multiply, multiply-accumulate and divide.
module muldiv_core
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] res_c
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0]    prod_s;
  logic [DW-1:0]    prod_u;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic             b_zero;
  logic             ovf;

  // Products, quotients and remainders; divisor is forced to 1 on the special cases so the
  // raw divider never sees a zero divisor or the MIN/-1 overflow
  always_comb begin
    prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    min_val = {1'b1, {(WIDTH-1){1'b0}}};
    b_zero  = (b == {WIDTH{1'b0}});
    ovf     = (a == min_val) && (b == {WIDTH{1'b1}});
    b_safe  = (b_zero || ovf) ? WIDTH'(1) : b;
    q_s     = $signed(a) / $signed(b_safe);
    r_s     = $signed(a) % $signed(b_safe);
    q_u     = a / b_safe;
    r_u     = a % b_safe;
  end

  // Select the next {hi,lo}; non-arithmetic codes leave the accumulator untouched
  always_comb begin
    res_c = acc;
    case (op)
      MD_MULT:  res_c = prod_s;
      MD_MULTU: res_c = prod_u;
      MD_MADD:  res_c = acc + prod_s;
      MD_MADDU: res_c = acc + prod_u;
      MD_MSUB:  res_c = acc - prod_s;
      MD_MSUBU: res_c = acc - prod_u;
      MD_DIV: begin
        if (b_zero)   res_c = {a, {WIDTH{1'b1}}};
        else if (ovf) res_c = {{WIDTH{1'b0}}, min_val};
        else          res_c = {r_s, q_s};
      end
      MD_DIVU: begin
        if (b_zero) res_c = {a, {WIDTH{1'b1}}};
        else        res_c = {r_u, q_u};
      end
      default: res_c = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: issue FSM, latency counter, operand latches and HI/LO registers.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_c;
  logic [2*WIDTH-1:0] res_c;

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .acc   ({hi_q, lo_q}),
    .res_c (res_c)
  );

  // Next-state: accept new ops in IDLE, count down in RUN and commit on the last cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept_c = start && !cancel && !busy_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end else if (is_mul(op) || is_div(op)) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = is_div(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = res_c;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_muldiv_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        s_start, s_cancel;
  logic [3:0]  s_op;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done;
  logic [15:0] s_hi, s_lo;

  int ntests = 0;
  int nfail  = 0;

  muldiv_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .cancel(s_cancel), .op(s_op),
    .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit never issues while busy
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(start && busy)) else $error("start asserted while busy (32-bit unit)");
      assert (!(s_start && s_busy)) else $error("start asserted while busy (16-bit unit)");
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, exp_hi, exp_lo;
    int          lat;
    string       name;
  } v16_t;

  vec_t vecs [0:13];
  v16_t v16s [0:5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Preload HI/LO through mthi/mtlo, checking they are single-cycle and silent
  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op = MD_MTHI; a = h; b = 32'h0;
    tick();
    chk("mthi_busy", 64'(busy), 64'd0);
    op = MD_MTLO; a = l;
    tick();
    start = 1'b0; op = MD_NONE;
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
    chk("mthi_val", 64'(hi), 64'(h));
    chk("mtlo_val", 64'(lo), 64'(l));
  endtask

  // Issue one multi-cycle op, scramble inputs while it runs, and check latency and result.
  // Returns in the done cycle; cancel is pulsed in RUN cycle cancel_at (0 = never).
  task automatic run_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input int cancel_at, input string nm);
    int cyc;
    start = 1'b1; op = o; a = xa; b = xb;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      cancel = (cyc == cancel_at);
      a  = $urandom;
      b  = $urandom;
      op = 4'($urandom_range(0, 15));
      tick();
    end
    cancel = 1'b0;
    op = MD_NONE;
    chk({nm, "_lat"}, 64'(cyc), 64'(lat));
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  task automatic run16(input v16_t v);
    int cyc;
    s_start = 1'b1; s_op = v.op; s_a = v.a; s_b = v.b;
    tick();
    s_start = 1'b0;
    cyc = 0;
    while (s_busy === 1'b1 && cyc < 200) begin
      cyc++;
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      tick();
    end
    s_op = MD_NONE;
    chk({v.name, "_lat"}, 64'(cyc), 64'(v.lat));
    chk({v.name, "_done"}, 64'(s_done), 64'd1);
    chk({v.name, "_hi"}, 64'(s_hi), 64'(v.exp_hi));
    chk({v.name, "_lo"}, 64'(s_lo), 64'(v.exp_lo));
    tick();
    chk({v.name, "_done_end"}, 64'(s_done), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_neg"};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0000DEAD, 32'h0000BEEF, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
    vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        32'h0,        32'h0,        32'h00000007, 32'hFFFFFFFF, 10, "divu_by0"};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 10, "div_ovf"};
    vecs[5]  = '{MD_MADD,  32'd2,        32'd3,        32'h12345678, 32'hFFFFFFFF, 32'h12345679, 32'h00000005, 5,  "madd_carry"};
    vecs[6]  = '{MD_MSUBU, 32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5,  "msubu_wrap"};
    vecs[7]  = '{MD_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'h00000002, 32'h0000000E, 10, "divu"};
    vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10, "div_negdiv"};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFF8, 32'd0,        32'h0,        32'h0,        32'hFFFFFFF8, 32'hFFFFFFFF, 10, "div_by0"};
    vecs[10] = '{MD_MSUB,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h0000000A, 32'h00000000, 32'h00000010, 5,  "msub_neg"};
    vecs[11] = '{MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000001, 32'hFFFFFFFE, 32'h00000002, 5,  "maddu_max"};
    vecs[12] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, 5,  "mult_min"};
    vecs[13] = '{MD_MADD,  32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5,  "madd_wrap"};

    v16s[0] = '{MD_MULT,  16'hFFFE, 16'd3,    16'hFFFF, 16'hFFFA, 1, "w16_mult"};
    v16s[1] = '{MD_MULTU, 16'hFFFE, 16'd3,    16'h0002, 16'hFFFA, 1, "w16_multu"};
    v16s[2] = '{MD_DIV,   16'hFFF9, 16'd2,    16'hFFFF, 16'hFFFD, 3, "w16_div"};
    v16s[3] = '{MD_DIVU,  16'd7,    16'd0,    16'h0007, 16'hFFFF, 3, "w16_divu0"};
    v16s[4] = '{MD_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 3, "w16_ovf"};
    v16s[5] = '{MD_MSUBU, 16'd1,    16'd1,    16'h0000, 16'h7FFF, 1, "w16_msubu"};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_NONE; a = '0; b = '0;
    s_start = 1'b0; s_cancel = 1'b0; s_op = MD_NONE; s_a = '0; s_b = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    #3 reset = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             vecs[i].lat, 0, vecs[i].name);
      tick();
      chk({vecs[i].name, "_done_end"}, 64'(done), 64'd0);
    end

    // start together with cancel, MD_NONE and undefined codes change nothing
    write_hilo(32'h11, 32'h22);
    start = 1'b1; cancel = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd5;
    tick();
    chk("cancel_busy", 64'(busy), 64'd0);
    cancel = 1'b0; op = MD_NONE;
    tick();
    chk("none_busy", 64'(busy), 64'd0);
    op = 4'd15; a = 32'hFFFF;
    tick();
    chk("undef_busy", 64'(busy), 64'd0);
    op = 4'd11;
    tick();
    start = 1'b0; op = MD_NONE;
    tick();
    chk("noop_done", 64'(done), 64'd0);
    chk("noop_hi", 64'(hi), 64'h11);
    chk("noop_lo", 64'(lo), 64'h22);

    // cancel during RUN cycle 3 is ignored
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 3, "cancel_run");
    tick();

    // Asynchronous reset in div RUN cycle 4 clears outputs before the next edge
    write_hilo(32'hAAAA5555, 32'h5555AAAA);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = MD_NONE;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    #1 reset = 1'b0;
    tick();
    chk("arst_idle", 64'(busy), 64'd0);
    run_op(MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0, "post_rst_div");
    tick();

    // Back-to-back: mult issued in the done cycle of a div
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0, "b2b_div");
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h2, 32'hFFFFFFFA, 5, 0, "b2b_mult");
    tick();
    chk("b2b_done_end", 64'(done), 64'd0);

    // Scaled instance: WIDTH=16, MULT_LAT=1, DIV_LAT=3
    chk("w16_rst_hi", 64'(s_hi), 64'd0);
    for (int i = 0; i < 6; i++) begin
      run16(v16s[i]);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
